// File: rtl/io_out_fifo_if.sv
// ---------------------------------------------------------------------------
// io_out_fifo_if
// Bundles the CPU-side OUT write path and the peripheral-side drain
// handshake of the output FIFO.
//   slave  modport : used by the FIFO itself
//                    in : wr_en, wr_port, wr_data, out_ready
//                    out: stall, full, empty, count, out_valid,
//                         out_port, out_data
//   master modport : used by whatever drives the FIFO (CPU/peripheral
//                    model), with the directions reversed.
// ---------------------------------------------------------------------------
interface io_out_fifo_if #(
    parameter int WIDTH = 8,
    parameter int PBITS = 2,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
);
    logic             wr_en;
    logic [PBITS-1:0] wr_port;
    logic [WIDTH-1:0] wr_data;
    logic             stall;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             out_valid;
    logic [PBITS-1:0] out_port;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport slave (
        input  wr_en, wr_port, wr_data, out_ready,
        output stall, full, empty, count, out_valid, out_port, out_data
    );

    modport master (
        output wr_en, wr_port, wr_data, out_ready,
        input  stall, full, empty, count, out_valid, out_port, out_data
    );
endinterface

// File: rtl/io_out_fifo.sv
// ---------------------------------------------------------------------------
// io_out_fifo
// Output-side I/O buffer for the single-cycle CPU. Each OUT instruction
// pushes a {port, data} pair; an external peripheral drains the head entry
// through a valid/ready handshake. When the buffer is full, a write raises
// stall so the control unit holds the PC and retries the OUT instruction.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; empties the buffer
//   bus    : io_out_fifo_if.slave (write path, flags, head, out_ready)
// ---------------------------------------------------------------------------
module io_out_fifo #(
    parameter int WIDTH = 8,
    parameter int PBITS = 2,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    io_out_fifo_if.slave     bus
);
    typedef logic [PBITS+WIDTH-1:0] entry_t;

    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push;
    logic          pop;
    entry_t        head;

    // A push is refused while full (no write-through); a pop needs a valid head.
    assign push = bus.wr_en & ~full_q;
    assign pop  = ~empty_q & bus.out_ready;

    // Storage update; only the slot at the write pointer changes on a push.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wp_q] = {bus.wr_port, bus.wr_data};
        end
    end

    // Storage holds no meaningful state after reset, so it is not cleared.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer, count and flag next-state. Pointers wrap naturally because
    // DEPTH is a power of two; flags are derived from the next count so they
    // come straight out of flops.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) begin
            wp_d = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Head is a plain combinational read, so it stays put until a pop moves rp.
    assign head          = mem_q[rp_q];
    assign bus.out_port  = head[PBITS+WIDTH-1:WIDTH];
    assign bus.out_data  = head[WIDTH-1:0];
    assign bus.out_valid = ~empty_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;

    // stall depends only on wr_en and the registered flag, never on out_ready,
    // so there is no combinational loop through the peripheral.
    assign bus.stall     = bus.wr_en & full_q & ~reset;
endmodule

// File: tb/tb_io_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_io_out_fifo
// Drives the output FIFO through directed scenarios and a randomized phase,
// comparing every observable against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_io_out_fifo;
    localparam int WIDTH = 8;
    localparam int PBITS = 2;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Reference model: the FIFO contents as an ordered list of {port, data}.
    logic [PBITS+WIDTH-1:0] model[$];

    io_out_fifo_if #(.WIDTH(WIDTH), .PBITS(PBITS), .DEPTH(DEPTH), .AW(AW)) bus ();

    io_out_fifo #(.WIDTH(WIDTH), .PBITS(PBITS), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compares every registered/head output against the model contents.
    task automatic checkState(input string tag);
        checkOutput({tag, ".count"}, 32'(bus.count), 32'(model.size()));
        checkOutput({tag, ".empty"}, 32'(bus.empty), 32'(model.size() == 0));
        checkOutput({tag, ".full"}, 32'(bus.full), 32'(model.size() == DEPTH));
        checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'(model.size() != 0));
        if (model.size() != 0) begin
            checkOutput({tag, ".port"}, 32'(bus.out_port), 32'(model[0][PBITS+WIDTH-1:WIDTH]));
            checkOutput({tag, ".data"}, 32'(bus.out_data), 32'(model[0][WIDTH-1:0]));
        end
    endtask

    // One clock cycle: drive inputs (called just after a falling edge), check
    // the combinational stall, advance the model at the rising edge, then
    // check state at the following falling edge. Returns whether the write
    // was accepted so callers can retry stalled writes like the CPU does.
    task automatic applyStimulus(input logic we, input logic [PBITS-1:0] port,
                                 input logic [WIDTH-1:0] data, input logic rdy,
                                 input string tag, output logic accepted);
        bit do_push;
        bit do_pop;
        bus.wr_en     = we;
        bus.wr_port   = port;
        bus.wr_data   = data;
        bus.out_ready = rdy;
        #1;
        checkOutput({tag, ".stall"}, 32'(bus.stall), 32'(we && model.size() == DEPTH));
        do_push = we && (model.size() < DEPTH);
        do_pop  = rdy && (model.size() > 0);
        @(posedge clk);
        if (do_pop) void'(model.pop_front());
        if (do_push) model.push_back({port, data});
        accepted = do_push;
        @(negedge clk);
        checkState(tag);
    endtask

    // Drain everything with out_ready high, bounded by a cycle budget.
    task automatic drainAll(input string tag);
        logic acc;
        int   budget;
        budget = 0;
        while (model.size() != 0 && budget < 20) begin
            applyStimulus(1'b0, '0, '0, 1'b1, tag, acc);
            budget++;
        end
        checkOutput({tag, ".drained"}, 32'(model.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        int   idx;
        int   budget;
        checks   = 0;
        failures = 0;
        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_port   = '0;
        bus.wr_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkState("por");

        // A little traffic, then a mid-stream reset.
        applyStimulus(1'b1, 2'd1, 8'h33, 1'b0, "pre", acc);
        applyStimulus(1'b1, 2'd3, 8'h44, 1'b0, "pre", acc);
        #2 reset = 1'b1;
        model.delete();
        #1;
        checkState("rst1");
        @(negedge clk);
        reset = 1'b0;
        checkState("rst1rel");

        // Single push becomes visible after one edge.
        applyStimulus(1'b1, 2'd2, 8'hA5, 1'b0, "single", acc);
        checkOutput("single.pdata", 32'(bus.out_data), 32'hA5);
        drainAll("drain0");

        // Fill, stall, pop one, retry.
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, PBITS'(i), WIDTH'(i), 1'b0, "fill", acc);
        checkOutput("fill.full", 32'(bus.full), 32'd1);
        applyStimulus(1'b1, 2'd1, 8'h05, 1'b0, "stall", acc);
        checkOutput("stall.refused", 32'(acc), 32'd0);
        applyStimulus(1'b1, 2'd1, 8'h05, 1'b1, "stallpop", acc);
        checkOutput("stallpop.refused", 32'(acc), 32'd0);
        applyStimulus(1'b1, 2'd1, 8'h05, 1'b0, "retry", acc);
        checkOutput("retry.accepted", 32'(acc), 32'd1);
        drainAll("drain1");

        // Wrap-around ordering with random backpressure; stalled writes retried.
        idx    = 0;
        budget = 0;
        while ((idx < 10 || model.size() != 0) && budget < 200) begin
            if (idx < 10) begin
                applyStimulus(1'b1, PBITS'(idx % 4), WIDTH'(8'h10 + idx),
                              1'($urandom_range(0, 1)), "wrap", acc);
                if (acc) idx++;
            end else begin
                applyStimulus(1'b0, '0, '0, 1'($urandom_range(0, 1)), "wrapdrain", acc);
            end
            budget++;
        end
        checkOutput("wrap.done", 32'(idx), 32'd10);

        // Simultaneous push and pop at count 2.
        applyStimulus(1'b1, 2'd0, 8'h61, 1'b0, "sim", acc);
        applyStimulus(1'b1, 2'd1, 8'h62, 1'b0, "sim", acc);
        applyStimulus(1'b1, 2'd2, 8'h63, 1'b1, "simboth", acc);
        checkOutput("simboth.count", 32'(bus.count), 32'd2);
        checkOutput("simboth.head", 32'(bus.out_data), 32'h62);

        // Backpressure hold.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, "hold", acc);
        checkOutput("hold.head", 32'(bus.out_data), 32'h62);
        drainAll("drain2");

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 1)), PBITS'($urandom), WIDTH'($urandom),
                          1'($urandom_range(0, 1)), "rand", acc);
        drainAll("drain3");

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, PBITS'(i), WIDTH'(8'hC0 + i), 1'b0, "q3", acc);
        bus.wr_en = 1'b1;
        #2 reset = 1'b1;
        model.delete();
        #1;
        checkState("arst");
        checkOutput("arst.stall", 32'(bus.stall), 32'd0);
        bus.wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkState("arstrel");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, '0, '0, 1'b1, "postrst", acc);
        applyStimulus(1'b1, 2'd3, 8'h7E, 1'b0, "postpush", acc);
        checkOutput("postpush.data", 32'(bus.out_data), 32'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
